// File: rtl/spi_arbiter.sv
// spi_arbiter: round-robin arbiter that shares one spi_core transfer channel
// between N_REQ requesters. It runs one complete SPI transaction per grant,
// then returns the read word and a one-cycle done pulse to the winner.
// Optional build macro: SPI_ARB_TIMEOUT_EN adds a transfer timeout that
// finishes a stuck transaction with req_err=1 and an all-ones read word.
module spi_arbiter #(
    parameter int N_REQ       = 2,
    parameter int DATA_W      = 32,
    parameter int TIMEOUT_CYC = 4096
) (
    input  logic                      clk,
    input  logic                      reset_n,
    input  logic [N_REQ-1:0]          req_go,
    input  logic [N_REQ*DATA_W-1:0]   req_wdata,
    output logic [N_REQ-1:0]          req_grant,
    output logic [N_REQ-1:0]          req_done,
    output logic [DATA_W-1:0]         req_rdata,
    output logic                      req_err,
    output logic                      spi_go_transfer,
    output logic [DATA_W-1:0]         spi_data_write,
    input  logic [DATA_W-1:0]         spi_data_read,
    input  logic                      spi_transfer_complete,
    output logic                      busy
);

    localparam int PTR_W = (N_REQ > 1) ? $clog2(N_REQ) : 1;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_XFER,
        ST_RELEASE,
        ST_DONE
    } state_t;

    state_t              state_q, state_d;
    logic [N_REQ-1:0]    grant_q, grant_d;
    logic [N_REQ-1:0]    done_q, done_d;
    logic [DATA_W-1:0]   rdata_q, rdata_d;
    logic [DATA_W-1:0]   hold_q, hold_d;
    logic [DATA_W-1:0]   wdata_q, wdata_d;
    logic                go_q, go_d;
    logic                busy_q, busy_d;
    logic [PTR_W-1:0]    ptr_q, ptr_d;

    logic                win_valid;
    logic [PTR_W-1:0]    win_idx;
    logic [PTR_W:0]      cand;
    logic [N_REQ-1:0]    win_onehot;
    logic [DATA_W-1:0]   win_wdata;

    logic                timeout_hit;
    logic                timeout_take;

    // Round-robin search: first set req_go bit starting just after the last winner, wrapping.
    always_comb begin
        win_valid = 1'b0;
        win_idx   = '0;
        cand      = '0;
        for (int i = 1; i <= N_REQ; i++) begin
            cand = {1'b0, ptr_q} + (PTR_W + 1)'(i);
            if (cand >= (PTR_W + 1)'(N_REQ)) begin
                cand = cand - (PTR_W + 1)'(N_REQ);
            end
            if (!win_valid && req_go[cand[PTR_W-1:0]]) begin
                win_valid = 1'b1;
                win_idx   = cand[PTR_W-1:0];
            end
        end
    end

    // Decode the winner into a one-hot grant and select only its write word.
    always_comb begin
        win_onehot          = '0;
        win_onehot[win_idx] = win_valid;
        win_wdata           = '0;
        for (int j = 0; j < N_REQ; j++) begin
            if (PTR_W'(j) == win_idx) begin
                win_wdata = req_wdata[j*DATA_W +: DATA_W];
            end
        end
    end

    // Next-state and registered-output logic of the transaction sequencer.
    always_comb begin
        state_d      = state_q;
        grant_d      = grant_q;
        done_d       = '0;
        rdata_d      = rdata_q;
        hold_d       = hold_q;
        wdata_d      = wdata_q;
        go_d         = go_q;
        ptr_d        = ptr_q;
        timeout_take = 1'b0;

        unique case (state_q)
            ST_IDLE: begin
                if (win_valid) begin
                    grant_d = win_onehot;
                    ptr_d   = win_idx;
                    wdata_d = win_wdata;
                    go_d    = 1'b1;
                    state_d = ST_XFER;
                end
            end
            ST_XFER: begin
                if (spi_transfer_complete) begin
                    hold_d  = spi_data_read;
                    go_d    = 1'b0;
                    state_d = ST_RELEASE;
                end else if (timeout_hit) begin
                    go_d         = 1'b0;
                    rdata_d      = '1;
                    done_d       = grant_q;
                    timeout_take = 1'b1;
                    state_d      = ST_DONE;
                end
            end
            ST_RELEASE: begin
                if (!spi_transfer_complete) begin
                    rdata_d = hold_q;
                    done_d  = grant_q;
                    state_d = ST_DONE;
                end else if (timeout_hit) begin
                    rdata_d      = '1;
                    done_d       = grant_q;
                    timeout_take = 1'b1;
                    state_d      = ST_DONE;
                end
            end
            ST_DONE: begin
                grant_d = '0;
                state_d = ST_IDLE;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase

        busy_d = (state_d != ST_IDLE);
    end

    // State and output registers with synchronous active-low reset.
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            state_q <= ST_IDLE;
            grant_q <= '0;
            done_q  <= '0;
            rdata_q <= '0;
            hold_q  <= '0;
            wdata_q <= '0;
            go_q    <= 1'b0;
            busy_q  <= 1'b0;
            ptr_q   <= PTR_W'(N_REQ - 1);
        end else begin
            state_q <= state_d;
            grant_q <= grant_d;
            done_q  <= done_d;
            rdata_q <= rdata_d;
            hold_q  <= hold_d;
            wdata_q <= wdata_d;
            go_q    <= go_d;
            busy_q  <= busy_d;
            ptr_q   <= ptr_d;
        end
    end

`ifdef SPI_ARB_TIMEOUT_EN
    localparam int CNT_W = $clog2(TIMEOUT_CYC + 1);

    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             err_q, err_d;

    // Count cycles spent waiting on spi_core; any visit to IDLE clears the count.
    always_comb begin
        cnt_d = '0;
        if (state_q == ST_XFER || state_q == ST_RELEASE) begin
            cnt_d = cnt_q + CNT_W'(1);
        end
        err_d = timeout_take;
    end

    assign timeout_hit = (state_q == ST_XFER || state_q == ST_RELEASE) &&
                         (cnt_q == CNT_W'(TIMEOUT_CYC - 1));

    // Timeout counter and error flag registers.
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            cnt_q <= '0;
            err_q <= 1'b0;
        end else begin
            cnt_q <= cnt_d;
            err_q <= err_d;
        end
    end

    assign req_err = err_q;
`else
    logic unused_timeout;

    assign timeout_hit    = 1'b0;
    assign unused_timeout = timeout_take | (TIMEOUT_CYC == 0);
    assign req_err        = 1'b0;
`endif

    assign req_grant       = grant_q;
    assign req_done        = done_q;
    assign req_rdata       = rdata_q;
    assign spi_go_transfer = go_q;
    assign spi_data_write  = wdata_q;
    assign busy            = busy_q;

endmodule

// File: tb/tb_spi_arbiter.sv
// tb_spi_arbiter: directed bench for spi_arbiter with a small behavioural
// spi_core responder (configurable completion delay, hold length, or never).
module tb_spi_arbiter;

    localparam int N = 2;
    localparam int W = 32;

    logic             clk = 1'b0;
    logic             reset_n = 1'b0;
    logic [N-1:0]     req_go = '0;
    logic [N*W-1:0]   req_wdata = '0;
    logic [N-1:0]     req_grant;
    logic [N-1:0]     req_done;
    logic [W-1:0]     req_rdata;
    logic             req_err;
    logic             spi_go_transfer;
    logic [W-1:0]     spi_data_write;
    logic [W-1:0]     spi_data_read = '0;
    logic             spi_transfer_complete = 1'b0;
    logic             busy;

    int               tests_run = 0;
    int               tests_failed = 0;

    int               model_delay = 5;
    int               model_hold = 1;
    bit               model_never = 1'b0;
    logic [W-1:0]     model_rdata = '0;
    int               mdl_cnt = 0;
    int               mdl_hold = 0;

    spi_arbiter #(
        .N_REQ(N),
        .DATA_W(W),
        .TIMEOUT_CYC(16)
    ) dut (
        .clk(clk),
        .reset_n(reset_n),
        .req_go(req_go),
        .req_wdata(req_wdata),
        .req_grant(req_grant),
        .req_done(req_done),
        .req_rdata(req_rdata),
        .req_err(req_err),
        .spi_go_transfer(spi_go_transfer),
        .spi_data_write(spi_data_write),
        .spi_data_read(spi_data_read),
        .spi_transfer_complete(spi_transfer_complete),
        .busy(busy)
    );

    // Free-running clock.
    initial begin
        forever #5 clk = ~clk;
    end

    // Behavioural spi_core: raise complete model_delay cycles into a transfer, hold it model_hold cycles.
    always @(posedge clk) begin
        #1;
        if (!reset_n) begin
            mdl_cnt = 0;
            mdl_hold = 0;
            spi_transfer_complete = 1'b0;
        end else if (mdl_hold > 0) begin
            mdl_hold = mdl_hold - 1;
            if (mdl_hold == 0) spi_transfer_complete = 1'b0;
        end else if (spi_go_transfer && !model_never) begin
            mdl_cnt = mdl_cnt + 1;
            if (mdl_cnt >= model_delay) begin
                spi_transfer_complete = 1'b1;
                spi_data_read = model_rdata;
                mdl_hold = model_hold;
                mdl_cnt = 0;
            end
        end else begin
            mdl_cnt = 0;
        end
    end

    task automatic do_reset();
        @(negedge clk);
        reset_n = 1'b0;
        req_go = '0;
        @(negedge clk);
        @(negedge clk);
        reset_n = 1'b1;
    endtask

    task automatic wait_done(input int max_cycles, output bit seen, output int cycles);
        seen = 1'b0;
        cycles = 0;
        while (!seen && cycles < max_cycles) begin
            @(negedge clk);
            cycles++;
            if (req_done != '0) seen = 1'b1;
        end
    endtask

    task automatic test_reset();
        @(negedge clk);
        reset_n = 1'b0;
        req_go = 2'b11;
        req_wdata = {32'hFFFF_0002, 32'hFFFF_0001};
        @(negedge clk);
        @(negedge clk);
        tests_run++;
        if (req_grant !== 2'b00) begin tests_failed++; $display("[TB] FAIL reset_grant: got %b expected 00", req_grant); end
        tests_run++;
        if (req_done !== 2'b00) begin tests_failed++; $display("[TB] FAIL reset_done: got %b expected 00", req_done); end
        tests_run++;
        if (req_rdata !== 32'h0) begin tests_failed++; $display("[TB] FAIL reset_rdata: got %h expected 0", req_rdata); end
        tests_run++;
        if (req_err !== 1'b0) begin tests_failed++; $display("[TB] FAIL reset_err: got %b expected 0", req_err); end
        tests_run++;
        if (spi_go_transfer !== 1'b0) begin tests_failed++; $display("[TB] FAIL reset_go: got %b expected 0", spi_go_transfer); end
        tests_run++;
        if (spi_data_write !== 32'h0) begin tests_failed++; $display("[TB] FAIL reset_wdata: got %h expected 0", spi_data_write); end
        tests_run++;
        if (busy !== 1'b0) begin tests_failed++; $display("[TB] FAIL reset_busy: got %b expected 0", busy); end
        req_go = '0;
        reset_n = 1'b1;
    endtask

    task automatic test_single();
        bit seen;
        int cyc;
        do_reset();
        model_delay = 40;
        model_hold = 1;
        model_never = 1'b0;
        model_rdata = 32'h1234_5678;
        req_wdata = {32'hDEAD_0001, 32'hA5A5_0001};
        req_go = 2'b01;
        @(negedge clk);
        tests_run++;
        if (spi_go_transfer !== 1'b1) begin tests_failed++; $display("[TB] FAIL single_go_latency: got %b expected 1", spi_go_transfer); end
        tests_run++;
        if (spi_data_write !== 32'hA5A5_0001) begin tests_failed++; $display("[TB] FAIL single_wdata: got %h expected a5a50001", spi_data_write); end
        tests_run++;
        if (req_grant !== 2'b01 || busy !== 1'b1) begin tests_failed++; $display("[TB] FAIL single_grant: got grant %b busy %b expected 01 1", req_grant, busy); end
        wait_done(200, seen, cyc);
        req_go = 2'b00;
        tests_run++;
        if (!seen || req_done !== 2'b01) begin tests_failed++; $display("[TB] FAIL single_done: got %b (seen %0d) expected 01", req_done, seen); end
        tests_run++;
        if (req_rdata !== 32'h1234_5678) begin tests_failed++; $display("[TB] FAIL single_rdata: got %h expected 12345678", req_rdata); end
        tests_run++;
        if (req_err !== 1'b0) begin tests_failed++; $display("[TB] FAIL single_err: got %b expected 0", req_err); end
        @(negedge clk);
        tests_run++;
        if (req_done !== 2'b00 || req_grant !== 2'b00 || busy !== 1'b0) begin
            tests_failed++;
            $display("[TB] FAIL single_after_done: got done %b grant %b busy %b expected 00 00 0", req_done, req_grant, busy);
        end
        tests_run++;
        if (req_rdata !== 32'h1234_5678) begin tests_failed++; $display("[TB] FAIL single_rdata_hold: got %h expected 12345678", req_rdata); end
    endtask

    task automatic test_contention();
        bit seen;
        bit bad;
        logic [1:0] exp_grant;
        logic [W-1:0] exp_w;
        do_reset();
        model_delay = 5;
        model_hold = 1;
        model_rdata = 32'h0000_C0DE;
        req_wdata = {32'hBBBB_1111, 32'hAAAA_0000};
        req_go = 2'b11;
        for (int t = 0; t < 4; t++) begin
            exp_grant = (t % 2 == 0) ? 2'b01 : 2'b10;
            exp_w = (t % 2 == 0) ? 32'hAAAA_0000 : 32'hBBBB_1111;
            seen = 1'b0;
            for (int c = 0; c < 50 && !seen; c++) begin
                @(negedge clk);
                if (spi_go_transfer) seen = 1'b1;
            end
            tests_run++;
            if (!seen || req_grant !== exp_grant) begin
                tests_failed++;
                $display("[TB] FAIL rr_grant_%0d: got %b (go seen %0d) expected %b", t, req_grant, seen, exp_grant);
            end
            bad = 1'b0;
            seen = 1'b0;
            for (int c = 0; c < 100 && !seen; c++) begin
                if (spi_go_transfer && spi_data_write !== exp_w) bad = 1'b1;
                @(negedge clk);
                if (req_done != '0) seen = 1'b1;
            end
            if (t == 3) req_go = 2'b00;
            tests_run++;
            if (bad) begin tests_failed++; $display("[TB] FAIL rr_wdata_%0d: got other data on spi_data_write, expected %h", t, exp_w); end
            tests_run++;
            if (!seen || req_done !== exp_grant) begin
                tests_failed++;
                $display("[TB] FAIL rr_done_%0d: got %b (seen %0d) expected %b", t, req_done, seen, exp_grant);
            end
        end
    endtask

    task automatic test_held_complete();
        int done_cnt;
        int rises;
        int early;
        logic go_prev;
        logic [W-1:0] rd;
        do_reset();
        model_delay = 3;
        model_hold = 10;
        model_rdata = 32'h0BAD_F00D;
        req_wdata = {32'h0, 32'h1111_2222};
        req_go = 2'b01;
        @(negedge clk);
        go_prev = spi_go_transfer;
        done_cnt = 0;
        rises = 0;
        early = 0;
        rd = '0;
        for (int c = 0; c < 40; c++) begin
            @(negedge clk);
            if (spi_go_transfer && !go_prev) rises++;
            go_prev = spi_go_transfer;
            if (req_done != '0) begin
                done_cnt++;
                if (spi_transfer_complete) early++;
                if (done_cnt == 1) rd = req_rdata;
                req_go = 2'b00;
            end
        end
        tests_run++;
        if (done_cnt != 1) begin tests_failed++; $display("[TB] FAIL held_done_count: got %0d expected 1", done_cnt); end
        tests_run++;
        if (early != 0) begin tests_failed++; $display("[TB] FAIL held_done_while_complete: got %0d expected 0", early); end
        tests_run++;
        if (rises != 0) begin tests_failed++; $display("[TB] FAIL held_second_go: got %0d expected 0", rises); end
        tests_run++;
        if (rd !== 32'h0BAD_F00D) begin tests_failed++; $display("[TB] FAIL held_rdata: got %h expected 0badf00d", rd); end
    endtask

    task automatic test_reset_mid();
        int dones;
        do_reset();
        model_delay = 100;
        model_hold = 1;
        req_wdata = {32'h0, 32'h5555_AAAA};
        req_go = 2'b01;
        repeat (4) @(negedge clk);
        tests_run++;
        if (spi_go_transfer !== 1'b1) begin tests_failed++; $display("[TB] FAIL midrst_pre_go: got %b expected 1", spi_go_transfer); end
        reset_n = 1'b0;
        req_go = 2'b00;
        @(negedge clk);
        reset_n = 1'b1;
        tests_run++;
        if (spi_go_transfer !== 1'b0) begin tests_failed++; $display("[TB] FAIL midrst_go: got %b expected 0", spi_go_transfer); end
        tests_run++;
        if (busy !== 1'b0) begin tests_failed++; $display("[TB] FAIL midrst_busy: got %b expected 0", busy); end
        tests_run++;
        if (req_grant !== 2'b00) begin tests_failed++; $display("[TB] FAIL midrst_grant: got %b expected 00", req_grant); end
        dones = 0;
        for (int c = 0; c < 60; c++) begin
            @(negedge clk);
            if (req_done != '0) dones++;
        end
        tests_run++;
        if (dones != 0) begin tests_failed++; $display("[TB] FAIL midrst_no_done: got %0d pulses expected 0", dones); end
    endtask

    task automatic test_timeout();
        int drops;
        int dones;
        bit seen;
        int cyc;
        do_reset();
        model_never = 1'b1;
        req_wdata = {32'h0, 32'h7777_0000};
        req_go = 2'b01;
        @(negedge clk);
        tests_run++;
        if (spi_go_transfer !== 1'b1) begin tests_failed++; $display("[TB] FAIL timeout_go: got %b expected 1", spi_go_transfer); end
`ifdef SPI_ARB_TIMEOUT_EN
        wait_done(40, seen, cyc);
        req_go = 2'b00;
        tests_run++;
        if (!seen || req_done !== 2'b01 || cyc != 16) begin
            tests_failed++;
            $display("[TB] FAIL timeout_done: got done %b after %0d cycles expected 01 after 16", req_done, cyc);
        end
        tests_run++;
        if (req_err !== 1'b1) begin tests_failed++; $display("[TB] FAIL timeout_err: got %b expected 1", req_err); end
        tests_run++;
        if (req_rdata !== 32'hFFFF_FFFF) begin tests_failed++; $display("[TB] FAIL timeout_rdata: got %h expected ffffffff", req_rdata); end
        drops = 0;
        dones = 0;
`else
        seen = 1'b0;
        cyc = 0;
        drops = 0;
        dones = 0;
        for (int c = 0; c < 1000; c++) begin
            @(negedge clk);
            if (busy !== 1'b1) drops++;
            if (req_done != '0) dones++;
        end
        tests_run++;
        if (drops != 0) begin tests_failed++; $display("[TB] FAIL notimeout_busy: got %0d idle cycles expected 0", drops); end
        tests_run++;
        if (dones != 0 || req_err !== 1'b0) begin
            tests_failed++;
            $display("[TB] FAIL notimeout_done: got %0d pulses err %b expected 0 0", dones, req_err);
        end
`endif
        do_reset();
        model_never = 1'b0;
    endtask

    task automatic test_late_request();
        bit seen;
        int cyc;
        do_reset();
        model_delay = 10;
        model_hold = 1;
        model_rdata = 32'h0000_0001;
        req_wdata = {32'hBBBB_0002, 32'hAAAA_0001};
        req_go = 2'b01;
        repeat (3) @(negedge clk);
        req_go = 2'b11;
        wait_done(100, seen, cyc);
        req_go = 2'b10;
        tests_run++;
        if (!seen || req_done !== 2'b01) begin tests_failed++; $display("[TB] FAIL late_first_done: got %b (seen %0d) expected 01", req_done, seen); end
        @(negedge clk);
        tests_run++;
        if (req_grant !== 2'b00) begin tests_failed++; $display("[TB] FAIL late_idle_grant: got %b expected 00", req_grant); end
        @(negedge clk);
        tests_run++;
        if (req_grant !== 2'b10 || spi_go_transfer !== 1'b1 || spi_data_write !== 32'hBBBB_0002) begin
            tests_failed++;
            $display("[TB] FAIL late_grant: got grant %b go %b wdata %h expected 10 1 bbbb0002", req_grant, spi_go_transfer, spi_data_write);
        end
        model_rdata = 32'h0000_0002;
        wait_done(100, seen, cyc);
        req_go = 2'b00;
        tests_run++;
        if (!seen || req_done !== 2'b10 || req_rdata !== 32'h0000_0002) begin
            tests_failed++;
            $display("[TB] FAIL late_second_done: got done %b rdata %h expected 10 00000002", req_done, req_rdata);
        end
        @(negedge clk);
    endtask

    // Run every scenario in order, then report.
    initial begin
        test_reset();
        test_single();
        test_contention();
        test_held_complete();
        test_reset_mid();
        test_timeout();
        test_late_request();
        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule

// File: doc/spi_arbiter.md
Name: spi_arbiter

Overview:
- Round-robin arbiter that shares the single spi_core transfer channel (go_transfer / write data / read data / data_pack_ready) between N_REQ requesters, e.g. avalon_slave plus a local sensor poller.
- Sits between the requesters and spi_core, in the same clock domain as spi_core.
- Sequences one complete SPI transaction per grant, then returns the read word and a done pulse to the granted requester.

Parameters:
- N_REQ, 2, number of requesters (2..8).
- DATA_W, 32, SPI word width.
- TIMEOUT_CYC, 4096, maximum cycles to wait for spi_transfer_complete. Used only with SPI_ARB_TIMEOUT_EN.

Ports:
- clk  in  1  block clock, shared with spi_core.
- reset_n  in  1  synchronous reset, active low.
- req_go  in  N_REQ  per-requester transfer request, level; held until that requester's req_done.
- req_wdata  in  N_REQ*DATA_W  packed write words; requester i uses bits [i*DATA_W +: DATA_W].
- req_grant  out  N_REQ  one-hot; shows the requester currently owning the SPI.
- req_done  out  N_REQ  one-cycle pulse to the granted requester at the end of its transfer.
- req_rdata  out  DATA_W  read word from the last transfer; valid from the req_done cycle until the next req_done.
- req_err  out  1  high with req_done when the transfer timed out; otherwise 0.
- spi_go_transfer  out  1  to spi_core go_transfer.
- spi_data_write  out  DATA_W  to spi_core data_write_from_avalon.
- spi_data_read  in  DATA_W  from spi_core data_read_to_avalon.
- spi_transfer_complete  in  1  from spi_core data_pack_ready, level.
- busy  out  1  high in every state except IDLE.

Behaviour:
Interface:
- One clock, clk; reset_n is synchronous and active-low.
- All outputs are registered.

Reset (reset_n=0 at a rising edge):
- State = IDLE.
- req_grant, req_done, req_rdata, req_err, spi_go_transfer, spi_data_write and busy all 0.
- RR pointer = N_REQ-1, so requester 0 has first priority.
- Reset mid-transfer aborts at once: spi_go_transfer drops the next cycle and no req_done is issued.

State machine:
- IDLE: if any req_go bit is set, pick the first set bit searching from (ptr+1) mod N_REQ upward with wrap. Register grant, ptr<=winner, spi_data_write<=req_wdata slice of winner, spi_go_transfer<=1, then go to XFER. Latency from req_go to spi_go_transfer is 1 cycle.
- XFER: hold spi_go_transfer=1 and spi_data_write stable. When spi_transfer_complete=1: capture req_rdata<=spi_data_read, set spi_go_transfer<=0, go to RELEASE.
- RELEASE: wait for spi_transfer_complete=0 (level handshake, prevents double-counting one completion), then go to DONE.
- DONE: req_done[winner]=1 for exactly one cycle, then req_grant<=0 and go to IDLE.

Handshake rules:
- A requester must drop req_go on the cycle after it sees req_done. If req_go is still high in IDLE, the requester is treated as a new request.
- req_go bits from non-granted requesters are ignored while busy, and their req_wdata is not sampled.
- A requester that deasserts req_go while granted does not abort the transfer; it still receives req_done.

Boundary conditions:
- Simultaneous requests in IDLE: the RR winner is served. A requester that waits is guaranteed service within N_REQ grants.
- spi_transfer_complete already high on entry to XFER (stale level): treated as completion. spi_core guarantees complete=0 before go.
- Back-to-back throughput: minimum 4 cycles of arbiter overhead per transfer (IDLE, XFER≥1, RELEASE≥1, DONE).

Optional Feature:
- Macro SPI_ARB_TIMEOUT_EN.
- Defined: a cycle counter runs in XFER and RELEASE. When it reaches TIMEOUT_CYC:
  - spi_go_transfer<=0 and req_rdata<={DATA_W{1'b1}}.
  - Go to DONE; req_done pulses with req_err=1.
  - The counter clears in IDLE.
- Undefined: no counter; req_err is tied to 0; XFER and RELEASE wait indefinitely.

Test Plan:
- Single request: reset, then req_go=01, req_wdata[0]=0xA5A5_0001; model completes after 40 cycles with spi_data_read=0x1234_5678. Required: spi_go_transfer high 1 cycle after req_go with spi_data_write=0xA5A5_0001; req_done=01 for 1 cycle; req_rdata=0x1234_5678; req_err=0.
- Contention RR: req_go=11 held continuously, each requester re-requesting after its done. Required: grant order 0,1,0,1 across 4 transfers, and req_wdata of the non-granted requester never appears on spi_data_write.
- Held complete: model keeps spi_transfer_complete high 10 cycles. Required: exactly one req_done; state stays in RELEASE until complete=0; no second spi_go_transfer in that window.
- Reset mid-transfer: reset_n=0 for 1 cycle while in XFER. Required: next cycle spi_go_transfer=0, busy=0, req_grant=0, and no req_done pulse.
- Timeout (SPI_ARB_TIMEOUT_EN, TIMEOUT_CYC=16): model never asserts complete. Required: after 16 cycles in XFER, req_done=01 with req_err=1 and req_rdata=0xFFFF_FFFF; without the macro, busy stays 1 for 1000 cycles.
- Late request: req_go[1] rises during requester 0's XFER. Required: requester 1 is granted in the IDLE cycle immediately after requester 0's DONE.
